// File: rtl/ball_render.sv
// ball_render: display-side renderer for the ball object.
// - Counts completed frames and issues a one-cycle `move` strobe every frame_div frames.
// - Holds a shadow copy of the ball centre that only reloads after a move strobe
//   or on the first cycle out of reset, so the ball never tears mid-frame.
// - Three-stage hit-test pipeline: |delta| -> delta^2 -> radius compare/colour;
//   syncs are delayed by the same three cycles.
// Optional build macro: BALL_OUTLINE_EN adds an outline_rgb ring of width 2 pixels
// at the rim of the ball (parameter outline_rgb exists only in that build).
module ball_render #(
  parameter int          width       = 1024,
  parameter int          height      = 768,
  parameter int          ball_radius = 16,
  parameter int          frame_div   = 1,
  parameter logic [11:0] ball_rgb    = 12'hF00,
  parameter logic [11:0] bg_rgb      = 12'h000,
`ifdef BALL_OUTLINE_EN
  parameter logic [11:0] outline_rgb = 12'hFFF,
`endif
  localparam int         h_width     = $clog2(width),
  localparam int         v_width     = $clog2(height)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [h_width-1:0] pixel_x,
  input  logic [v_width-1:0] pixel_y,
  input  logic               video_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [h_width-1:0] ball_x,
  input  logic [v_width-1:0] ball_y,
  output logic               move,
  output logic [11:0]        rgb,
  output logic               hsync_out,
  output logic               vsync_out
);

  localparam int MAX_W = (h_width > v_width) ? h_width : v_width;
  localparam int SUM_W = 2 * MAX_W + 1;
  localparam int CNT_W = (frame_div > 1) ? $clog2(frame_div) : 1;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(frame_div - 1);
  localparam logic [h_width-1:0] X_LAST   = h_width'(width - 1);
  localparam logic [v_width-1:0] Y_LAST   = v_width'(height - 1);
  localparam logic [SUM_W-1:0]   R2       = SUM_W'(ball_radius * ball_radius);
`ifdef BALL_OUTLINE_EN
  localparam logic [SUM_W-1:0]   R2_IN    = SUM_W'((ball_radius - 2) * (ball_radius - 2));
`endif

  // Unsigned |a-b| without a sign bit: compare first, then subtract the smaller.
  function automatic logic [h_width-1:0] abs_diff_x(input logic [h_width-1:0] a,
                                                     input logic [h_width-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [v_width-1:0] abs_diff_y(input logic [v_width-1:0] a,
                                                     input logic [v_width-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [2*h_width-1:0] square_x(input logic [h_width-1:0] v);
    logic [2*h_width-1:0] e;
    e = {{h_width{1'b0}}, v};
    return e * e;
  endfunction

  function automatic logic [2*v_width-1:0] square_y(input logic [v_width-1:0] v);
    logic [2*v_width-1:0] e;
    e = {{v_width{1'b0}}, v};
    return e * e;
  endfunction

  logic [CNT_W-1:0]     count;
  logic                 reset_d;
  logic [h_width-1:0]   shadow_x;
  logic [v_width-1:0]   shadow_y;
  logic                 frame_end;

  logic [h_width-1:0]   dx_p1;
  logic [v_width-1:0]   dy_p1;
  logic                 vld_p1, hs_p1, vs_p1;
  logic [2*h_width-1:0] dx2_p2;
  logic [2*v_width-1:0] dy2_p2;
  logic                 vld_p2, hs_p2, vs_p2;
  logic [SUM_W-1:0]     dist2;
  logic                 hit;
`ifdef BALL_OUTLINE_EN
  logic                 inner;
`endif

  assign frame_end = video_on && (pixel_x == X_LAST) && (pixel_y == Y_LAST);

  // Frame counter; move is registered so it lands on the cycle after frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      move  <= 1'b0;
    end else begin
      move <= 1'b0;
      if (frame_end) begin
        if (count == CNT_LAST) begin
          count <= '0;
          move  <= 1'b1;
        end else begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

  // Shadow centre: reload after a move strobe (controller has just stepped)
  // or on the first cycle out of reset; otherwise hold for the whole frame.
  always_ff @(posedge clk) begin
    reset_d <= reset;
    if (reset) begin
      shadow_x <= '0;
      shadow_y <= '0;
    end else if (move || reset_d) begin
      shadow_x <= ball_x;
      shadow_y <= ball_y;
    end
  end

  // ---- stage 1: absolute distance from the shadow centre ----
  always_ff @(posedge clk) begin
    if (reset) begin
      dx_p1  <= '0;
      dy_p1  <= '0;
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
    end else begin
      dx_p1  <= abs_diff_x(pixel_x, shadow_x);
      dy_p1  <= abs_diff_y(pixel_y, shadow_y);
      vld_p1 <= video_on;
      hs_p1  <= hsync_in;
      vs_p1  <= vsync_in;
    end
  end

  // ---- stage 2: squared distances ----
  always_ff @(posedge clk) begin
    if (reset) begin
      dx2_p2 <= '0;
      dy2_p2 <= '0;
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
    end else begin
      dx2_p2 <= square_x(dx_p1);
      dy2_p2 <= square_y(dy_p1);
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  // ---- stage 3: radius compare and colour select ----
  // The sum is one bit wider than either square so it can never wrap.
  assign dist2 = SUM_W'(dx2_p2) + SUM_W'(dy2_p2);
  assign hit   = (dist2 <= R2);
`ifdef BALL_OUTLINE_EN
  assign inner = (dist2 <= R2_IN);
`endif

  // Output register: colour is forced to black outside the active region.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb       <= 12'h000;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      hsync_out <= hs_p2;
      vsync_out <= vs_p2;
      if (!vld_p2) begin
        rgb <= 12'h000;
`ifdef BALL_OUTLINE_EN
      end else if (inner) begin
        rgb <= ball_rgb;
      end else if (hit) begin
        rgb <= outline_rgb;
`else
      end else if (hit) begin
        rgb <= ball_rgb;
`endif
      end else begin
        rgb <= bg_rgb;
      end
    end
  end

endmodule

// File: tb/tb_ball_render.sv
// Directed testbench for ball_render (frame_div=3, r=16, default colours).
// Frame ends are emulated by driving the last active pixel for one cycle.
module tb_ball_render;

  logic       clk;
  logic       reset;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       hsync_in;
  logic       vsync_in;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       move;
  logic [11:0] rgb;
  logic       hsync_out;
  logic       vsync_out;

  int errors = 0;
  int checks = 0;

  ball_render #(.frame_div(3)) dut (
    .clk(clk), .reset(reset),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .ball_x(ball_x), .ball_y(ball_y),
    .move(move), .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A move strobe must never coincide with a frame-end pixel (shadow load vs frame end).
  always @(posedge clk) begin
    if (!reset && move && video_on && pixel_x == 10'd1023 && pixel_y == 10'd767) begin
      errors++;
      $display("FAIL move_vs_frame_end: move=%0b at frame end, required 0", move);
    end
  end

  task automatic drive(input int x, input int y, input logic vo);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = vo;
  endtask

  // Hold a pixel long enough for it to reach the output, then return the colour.
  task automatic render(input int x, input int y, input logic vo, output logic [11:0] got);
    drive(x, y, vo);
    repeat (3) @(negedge clk);
    got = rgb;
  endtask

  // One emulated frame: two active pixels, the frame-end pixel, one blanking cycle.
  // Each sample reflects the move register after the cycle just driven.
  task automatic one_frame(input logic expect_move, output int seen);
    logic exp;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (c < 2)       drive(c, 0, 1'b1);
      else if (c == 2) drive(1023, 767, 1'b1);
      else             drive(0, 0, 1'b0);
      @(negedge clk);
      exp = (c == 2) ? expect_move : 1'b0;
      if (move) seen++;
      checks++;
      if (move !== exp) begin
        errors++;
        $display("FAIL frame_move_c%0d: move=%0b required %0b", c, move, exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ball_x = 10'd512;
    ball_y = 10'd384;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    drive(512, 384, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rgb !== 12'h000 || move !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_%0d: rgb=%h move=%0b required 000/0", i, rgb, move);
      end
    end
    reset = 1'b0;
    // Shadow loads on the first edge after release, so the centre pixel hits 4 edges later.
    for (int i = 1; i <= 4; i++) begin
      logic [11:0] exp;
      @(negedge clk);
      exp = (i == 4) ? 12'hF00 : 12'h000;
      checks++;
      if (rgb !== exp || move !== 1'b0) begin
        errors++;
        $display("FAIL reset_release_%0d: rgb=%h move=%0b required %h/0", i, rgb, move, exp);
      end
    end
  endtask

  task automatic test_latency();
    logic [11:0] exp;
    drive(512, 384, 1'b0);
    repeat (3) @(negedge clk);
    drive(512, 384, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(512, 384, 1'b0);
      exp = (i == 3) ? 12'hF00 : 12'h000;
      checks++;
      if (rgb !== exp) begin
        errors++;
        $display("FAIL latency_%0d: rgb=%h required %h", i, rgb, exp);
      end
    end
  endtask

  task automatic test_hit_boundary();
    int xs [7] = '{512, 528, 529, 524, 496, 512, 512};
    int ys [7] = '{384, 384, 384, 396, 384, 400, 401};
    logic [11:0] ex [7] = '{12'hF00, 12'hF00, 12'h000, 12'h000, 12'hF00, 12'hF00, 12'h000};
    logic [11:0] got;
    for (int i = 0; i < 7; i++) begin
      render(xs[i], ys[i], 1'b1, got);
      checks++;
      if (got !== ex[i]) begin
        errors++;
        $display("FAIL hit_%0d_%0d: rgb=%h required %h", xs[i], ys[i], got, ex[i]);
      end
    end
  endtask

  task automatic test_frames();
    int seen;
    int total = 0;
    for (int f = 1; f <= 6; f++) begin
      one_frame((f % 3) == 0, seen);
      total += seen;
    end
    checks++;
    if (total !== 2) begin
      errors++;
      $display("FAIL frame_move_total: moves=%0d required 2", total);
    end
  endtask

  task automatic test_shadow_hold();
    logic [11:0] got;
    int seen;
    ball_x = 10'd600;
    render(512, 384, 1'b1, got);
    checks++;
    if (got !== 12'hF00) begin errors++; $display("FAIL hold_old_centre: rgb=%h required f00", got); end
    render(600, 384, 1'b1, got);
    checks++;
    if (got !== 12'h000) begin errors++; $display("FAIL hold_new_centre: rgb=%h required 000", got); end
    one_frame(1'b0, seen);
    one_frame(1'b0, seen);
    render(600, 384, 1'b1, got);
    checks++;
    if (got !== 12'h000) begin errors++; $display("FAIL hold_two_frames: rgb=%h required 000", got); end
    one_frame(1'b1, seen);
    render(600, 384, 1'b1, got);
    checks++;
    if (got !== 12'hF00) begin errors++; $display("FAIL moved_new_centre: rgb=%h required f00", got); end
    render(512, 384, 1'b1, got);
    checks++;
    if (got !== 12'h000) begin errors++; $display("FAIL moved_old_centre: rgb=%h required 000", got); end
  endtask

  task automatic test_blank_and_sync();
    logic [11:0] got;
    logic eh, ev;
    render(600, 384, 1'b0, got);
    checks++;
    if (got !== 12'h000) begin errors++; $display("FAIL blank_hit: rgb=%h required 000", got); end
    // hsync high for inputs 1..2, vsync for 1..3; output at sample i reflects input i-2.
    for (int i = 0; i < 8; i++) begin
      hsync_in = (i == 1 || i == 2);
      vsync_in = (i >= 1 && i <= 3);
      @(negedge clk);
      eh = (i - 2 == 1 || i - 2 == 2);
      ev = (i - 2 >= 1 && i - 2 <= 3);
      checks++;
      if (hsync_out !== eh || vsync_out !== ev) begin
        errors++;
        $display("FAIL sync_%0d: hs=%0b vs=%0b required %0b/%0b", i, hsync_out, vsync_out, eh, ev);
      end
    end
    hsync_in = 1'b0;
    vsync_in = 1'b0;
  endtask

  task automatic test_outline();
    int xs [3] = '{115, 113, 117};
    logic [11:0] ex [3];
    logic [11:0] got;
    int seen;
`ifdef BALL_OUTLINE_EN
    ex = '{12'hFFF, 12'hF00, 12'h000};
`else
    ex = '{12'hF00, 12'hF00, 12'h000};
`endif
    ball_x = 10'd100;
    ball_y = 10'd100;
    one_frame(1'b0, seen);
    one_frame(1'b0, seen);
    one_frame(1'b1, seen);
    for (int i = 0; i < 3; i++) begin
      render(xs[i], 100, 1'b1, got);
      checks++;
      if (got !== ex[i]) begin
        errors++;
        $display("FAIL outline_%0d: rgb=%h required %h", xs[i], got, ex[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_hit_boundary();
    test_frames();
    test_shadow_hold();
    test_blank_and_sync();
    test_outline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
